// File: rtl/obi_mem_responder.sv
// OBI memory responder: word memory window, fixed-latency in-order responses.
// Ports: clk_i, rst_ni, obi_req_i, obi_resp_o, stall_i, oob_count_o.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } rsp_slot_t;

endpackage

module obi_mem_responder
  import obi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h2001_0000,
  parameter int unsigned NUM_WORDS       = 256,
  parameter int unsigned LATENCY         = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] ERR_RDATA       = 32'hBADACCE5
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  obi_req_t    obi_req_i,
  output obi_resp_t   obi_resp_o,
  input  logic        stall_i,
  output logic [15:0] oob_count_o
);

  localparam int unsigned AW = $clog2(NUM_WORDS);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] WIN_BYTES = 32'(NUM_WORDS * 4);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  logic [31:0]   mem [NUM_WORDS];
  rsp_slot_t     pipe [LATENCY];
  logic [CW-1:0] outstanding;
  logic [15:0]   oob_count;

  logic [31:0]   off;
  logic          in_win;
  logic [AW-1:0] idx;
  logic          retire;
  logic          gnt;
  logic [31:0]   rd_word;

  assign off    = obi_req_i.addr - BASE_ADDR;
  assign in_win = off < WIN_BYTES;
  assign idx    = off[2 +: AW];
  assign retire = pipe[LATENCY-1].valid;

  // A retiring response frees its slot in the same cycle.
  assign gnt = rst_ni & obi_req_i.req & ~stall_i
             & ((outstanding < MAX_CNT) | retire);

  always_comb begin
    rd_word = '0;
    if (!obi_req_i.we) begin
      rd_word = in_win ? mem[idx] : ERR_RDATA;
    end
  end

  always_ff @(posedge clk_i) begin
    if (gnt && obi_req_i.we && in_win) begin
      for (int i = 0; i < 4; i++) begin
        if (obi_req_i.be[i]) begin
          mem[idx][8*i +: 8] <= obi_req_i.wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe[i] <= '0;
      end
      outstanding <= '0;
      oob_count   <= '0;
    end else begin
      pipe[0] <= gnt ? {1'b1, rd_word} : '0;
      for (int i = 1; i < LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
      unique case (1'b1)
        gnt && !retire: outstanding <= outstanding + 1'b1;
        retire && !gnt: outstanding <= outstanding - 1'b1;
        default: ;
      endcase
      if (gnt && !in_win && oob_count != 16'hFFFF) begin
        oob_count <= oob_count + 16'd1;
      end
    end
  end

  assign obi_resp_o  = {gnt, pipe[LATENCY-1].valid, pipe[LATENCY-1].data};
  assign oob_count_o = oob_count;

endmodule

// File: tb/tb_obi_mem_responder.sv
// Bench for obi_mem_responder: four configurations share one stimulus
// stream and are each checked against a cycle-level behavioural model.
module tb_obi_mem_responder;
  import obi_pkg::*;

  localparam int NI = 4;
  localparam logic [31:0] BASE = 32'h2001_0000;
  localparam logic [31:0] ERR = 32'hBADACCE5;

  function automatic int lat_of(input int i);
    case (i)
      0: return 1;
      1: return 2;
      2: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int mxo_of(input int i);
    case (i)
      0: return 2;
      1: return 1;
      2: return 2;
      default: return 3;
    endcase
  endfunction

  logic        clk;
  logic        rst_n;
  logic        stall;
  obi_req_t    oreq;
  obi_resp_t   rsp [NI];
  logic [15:0] oob [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    obi_mem_responder #(
      .LATENCY(lat_of(g)),
      .MAX_OUTSTANDING(mxo_of(g))
    ) u_dut (
      .clk_i(clk),
      .rst_ni(rst_n),
      .obi_req_i(oreq),
      .obi_resp_o(rsp[g]),
      .stall_i(stall),
      .oob_count_o(oob[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc_n = 0;

  logic [31:0] mm [NI][256];
  bit          sv [NI][8];
  int          sc [NI][8];
  logic [31:0] sd [NI][8];
  int          outst [NI];
  int          moob [NI];
  logic [31:0] oob_pool [5] = '{32'h2001_0400, 32'h2000_FFFC,
                                32'h1FFF_FFFC, 32'h0, 32'hFFFF_FFFC};

  task automatic chk(input string tag, input int i,
                     input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s dut%0d cyc%0d got=%h exp=%h",
             tag, i, cyc_n, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < 8; k++) sv[i][k] = 1'b0;
      outst[i] = 0;
      moob[i] = 0;
    end
  endtask

  // One clock cycle: drive inputs, check outputs, advance the model
  // across the next rising edge.
  task automatic cyc(input logic rq, input logic we, input logic [3:0] be,
                     input logic [31:0] ad, input logic [31:0] wd,
                     input logic st, input logic rn);
    int slot, s2, w;
    logic erv, eg, inw;
    logic [31:0] erd, off, rd;
    @(negedge clk);
    oreq.req = rq;
    oreq.we = we;
    oreq.be = be;
    oreq.addr = ad;
    oreq.wdata = wd;
    stall = st;
    rst_n = rn;
    if (!rn) model_clear();
    #1;
    for (int i = 0; i < NI; i++) begin
      slot = cyc_n % 8;
      erv = sv[i][slot] && sc[i][slot] == cyc_n;
      erd = erv ? sd[i][slot] : 32'h0;
      eg = rn && rq && !st && (outst[i] < mxo_of(i) || erv);
      chk("gnt", i, 32'(rsp[i].gnt), 32'(eg));
      chk("rvalid", i, 32'(rsp[i].rvalid), 32'(erv));
      chk("rdata", i, rsp[i].rdata, erd);
      chk("oob", i, 32'(oob[i]), 32'(moob[i]));
      if (erv) begin
        sv[i][slot] = 1'b0;
        outst[i]--;
      end
      if (eg) begin
        off = ad - BASE;
        inw = off < 32'd1024;
        w = int'((off >> 2) % 256);
        if (!inw && moob[i] < 65535) moob[i]++;
        rd = we ? 32'h0 : (inw ? mm[i][w] : ERR);
        if (we && inw) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) mm[i][w][8*b +: 8] = wd[8*b +: 8];
        end
        s2 = (cyc_n + lat_of(i)) % 8;
        sv[i][s2] = 1'b1;
        sc[i][s2] = cyc_n + lat_of(i);
        sd[i][s2] = rd;
        outst[i]++;
      end
    end
    cyc_n++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 4'h0, 32'h0, 32'h0, 0, 1);
  endtask

  task automatic wr(input logic [31:0] ad, input logic [3:0] be,
                    input logic [31:0] wd);
    cyc(1, 1, be, ad, wd, 0, 1);
    idle(3);
  endtask

  task automatic rd(input logic [31:0] ad);
    cyc(1, 0, 4'h0, ad, 32'h0, 0, 1);
    idle(3);
  endtask

  initial begin
    logic [31:0] ad;
    int sel;
    oreq = '0;
    stall = 1'b0;
    rst_n = 1'b1;
    model_clear();
    cyc(1, 0, 4'hF, BASE, 32'h0, 0, 0);
    cyc(0, 0, 4'h0, 32'h0, 32'h0, 0, 0);
    idle(1);
    for (int w = 0; w < 17; w++) begin
      wr(BASE + 32'(4 * (w < 16 ? w : 255)), 4'hF, $urandom);
    end
    wr(32'h2001_0010, 4'hF, 32'hDEADBEEF);
    rd(32'h2001_0010);
    wr(32'h2001_0014, 4'hF, 32'h11223344);
    wr(32'h2001_0014, 4'b0101, 32'hAABBCCDD);
    rd(32'h2001_0014);
    for (int k = 0; k < 8; k++) cyc(1, 0, 4'h0, 32'h2001_0010, 0, 0, 1);
    idle(4);
    for (int k = 0; k < 8; k++) cyc(1, 0, 4'h0, BASE + 32'(4 * k), 0, 0, 1);
    idle(4);
    rd(32'h2001_0400);
    wr(32'h1FFF_FFFC, 4'hF, 32'h0BAD_0BAD);
    rd(32'h2001_03FC);
    rd(BASE);
    for (int k = 0; k < 3; k++) cyc(1, 0, 4'h0, 32'h2001_0014, 0, 1, 1);
    cyc(1, 0, 4'h0, 32'h2001_0014, 0, 0, 1);
    idle(4);
    for (int k = 0; k < 500; k++) begin
      sel = $urandom_range(0, 19);
      if (sel < 17) ad = BASE + 32'(4 * (sel < 16 ? sel : 255));
      else ad = oob_pool[$urandom_range(0, 4)];
      ad = ad + 32'($urandom_range(0, 3));
      cyc($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
          4'($urandom), ad, $urandom, $urandom_range(0, 4) == 0, 1);
    end
    idle(4);
    cyc(1, 0, 4'h0, 32'h2001_0010, 0, 0, 1);
    cyc(1, 0, 4'h0, 32'h2001_0014, 0, 0, 1);
    cyc(1, 0, 4'h0, 32'h2001_0018, 0, 0, 0);
    idle(5);
    rd(32'h2001_0010);
    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
